// File: rtl/knn_multi_core_if.sv
// Training-point stream into knn_multi_core: valid/ready handshake carrying coordinates, label and end-of-run flag.
interface knn_multi_core_if #(
    parameter int COORD_W = 16,
    parameter int IDX_W   = 8
);
    logic                      train_valid;
    logic                      train_ready;
    logic signed [COORD_W-1:0] train_x;
    logic signed [COORD_W-1:0] train_y;
    logic [IDX_W-1:0]          train_idx;
    logic                      train_last;

    modport master (output train_valid, train_x, train_y, train_idx, train_last, input train_ready);
    modport slave  (input train_valid, train_x, train_y, train_idx, train_last, output train_ready);
endinterface

// File: rtl/knn_multi_core.sv
// Parallel k-nearest-neighbour engine: N_SOLVERS test points, each with a sorted HW_K-deep list.
// Define KNN_MANHATTAN_EN to use |dx|+|dy| instead of squared Euclidean distance.
module knn_multi_core #(
    parameter int  COORD_W   = 16,
    parameter int  N_SOLVERS = 4,
    parameter int  HW_K      = 10,
    parameter int  IDX_W     = 8,
    localparam int SEL_W     = (N_SOLVERS > 1) ? $clog2(N_SOLVERS) : 1,
    localparam int POS_W     = (HW_K > 1) ? $clog2(HW_K) : 1,
    localparam int DIST_W    = 2*COORD_W + 2
) (
    input  logic                      clk,
    input  logic                      rst,
    knn_multi_core_if.slave           trn,
    input  logic                      start_i,
    input  logic                      test_we_i,
    input  logic [SEL_W-1:0]          test_sel_i,
    input  logic signed [COORD_W-1:0] test_x_i,
    input  logic signed [COORD_W-1:0] test_y_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic [SEL_W-1:0]          rd_solver_i,
    input  logic [POS_W-1:0]          rd_pos_i,
    output logic [IDX_W-1:0]          rd_idx_o,
    output logic [DIST_W-1:0]         rd_dist_o,
    output logic                      rd_vld_o
);
    localparam int DW = COORD_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    function automatic logic [DIST_W-1:0] calc_dist(input logic signed [DW-1:0] dx,
                                                    input logic signed [DW-1:0] dy);
`ifdef KNN_MANHATTAN_EN
        logic [DW-1:0] ax, ay;
        ax = dx[DW-1] ? DW'(-dx) : DW'(dx);
        ay = dy[DW-1] ? DW'(-dy) : DW'(dy);
        return DIST_W'(ax) + DIST_W'(ay);
`else
        logic signed [DIST_W-1:0] sx, sy;
        sx = DIST_W'(dx) * DIST_W'(dx);
        sy = DIST_W'(dy) * DIST_W'(dy);
        return $unsigned(sx) + $unsigned(sy);
`endif
    endfunction

    state_e state_q, state_d;
    logic   drain_q, drain_d;
    logic   accept, clear, test_wr_ok;

    logic signed [COORD_W-1:0] test_x_q [N_SOLVERS];
    logic signed [COORD_W-1:0] test_y_q [N_SOLVERS];

    logic signed [DW-1:0] dx_p1_q [N_SOLVERS];
    logic signed [DW-1:0] dy_p1_q [N_SOLVERS];
    logic [IDX_W-1:0]     idx_p1_q, idx_p2_q;
    logic [DIST_W-1:0]    dist_p2_q [N_SOLVERS];
    logic                 vld_p1_q, vld_p2_q;

    logic [DIST_W-1:0] list_dist_q [N_SOLVERS][HW_K];
    logic [DIST_W-1:0] list_dist_d [N_SOLVERS][HW_K];
    logic [IDX_W-1:0]  list_idx_q  [N_SOLVERS][HW_K];
    logic [IDX_W-1:0]  list_idx_d  [N_SOLVERS][HW_K];
    logic              list_vld_q  [N_SOLVERS][HW_K];
    logic              list_vld_d  [N_SOLVERS][HW_K];

    assign accept     = trn.train_valid & trn.train_ready;
    assign clear      = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign test_wr_ok = test_we_i & ((state_q == ST_IDLE) | (state_q == ST_DONE))
                        & (int'(test_sel_i) < N_SOLVERS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // The DRAIN dwell covers the two remaining pipeline stages behind the last accepted point.
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_RUN;
            ST_RUN:   if (accept && trn.train_last) state_d = ST_DRAIN;
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = ST_DONE;
            end
            ST_DONE:  if (start_i) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        trn.train_ready = (state_q == ST_RUN);
        busy_o          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done_o          = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SOLVERS; s++) begin
                test_x_q[s] <= '0;
                test_y_q[s] <= '0;
            end
        end else if (test_wr_ok) begin
            test_x_q[test_sel_i] <= test_x_i;
            test_y_q[test_sel_i] <= test_y_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
        end
    end

    // Stage 1: coordinate differences
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int s = 0; s < N_SOLVERS; s++) begin
                dx_p1_q[s] <= DW'(test_x_q[s]) - DW'(trn.train_x);
                dy_p1_q[s] <= DW'(test_y_q[s]) - DW'(trn.train_y);
            end
            idx_p1_q <= trn.train_idx;
        end
    end

    // Stage 2: distance
    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            for (int s = 0; s < N_SOLVERS; s++) begin
                dist_p2_q[s] <= calc_dist(dx_p1_q[s], dy_p1_q[s]);
            end
            idx_p2_q <= idx_p1_q;
        end
    end

    // Stage 3: sorted insert; strict compare keeps earlier arrivals ahead on ties
    always_comb begin
        list_dist_d = list_dist_q;
        list_idx_d  = list_idx_q;
        list_vld_d  = list_vld_q;
        for (int s = 0; s < N_SOLVERS; s++) begin
            if (clear) begin
                for (int i = 0; i < HW_K; i++) begin
                    list_dist_d[s][i] = '1;
                    list_idx_d[s][i]  = '0;
                    list_vld_d[s][i]  = 1'b0;
                end
            end else if (vld_p2_q) begin
                if (dist_p2_q[s] < list_dist_q[s][0]) begin
                    list_dist_d[s][0] = dist_p2_q[s];
                    list_idx_d[s][0]  = idx_p2_q;
                    list_vld_d[s][0]  = 1'b1;
                end
                for (int i = 1; i < HW_K; i++) begin
                    if (dist_p2_q[s] < list_dist_q[s][i] && dist_p2_q[s] >= list_dist_q[s][i-1]) begin
                        list_dist_d[s][i] = dist_p2_q[s];
                        list_idx_d[s][i]  = idx_p2_q;
                        list_vld_d[s][i]  = 1'b1;
                    end else if (dist_p2_q[s] < list_dist_q[s][i-1]) begin
                        list_dist_d[s][i] = list_dist_q[s][i-1];
                        list_idx_d[s][i]  = list_idx_q[s][i-1];
                        list_vld_d[s][i]  = list_vld_q[s][i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SOLVERS; s++) begin
                for (int i = 0; i < HW_K; i++) begin
                    list_dist_q[s][i] <= '1;
                    list_idx_q[s][i]  <= '0;
                    list_vld_q[s][i]  <= 1'b0;
                end
            end
        end else begin
            list_dist_q <= list_dist_d;
            list_idx_q  <= list_idx_d;
            list_vld_q  <= list_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_o  <= '0;
            rd_dist_o <= '0;
            rd_vld_o  <= 1'b0;
        end else if (int'(rd_solver_i) < N_SOLVERS && int'(rd_pos_i) < HW_K) begin
            rd_idx_o  <= list_idx_q[rd_solver_i][rd_pos_i];
            rd_dist_o <= list_dist_q[rd_solver_i][rd_pos_i];
            rd_vld_o  <= list_vld_q[rd_solver_i][rd_pos_i];
        end else begin
            rd_idx_o  <= '0;
            rd_dist_o <= '0;
            rd_vld_o  <= 1'b0;
        end
    end
endmodule
